// File: rtl/sa_out_drain.sv
// sa_out_drain: collects full systolic-array output frames into a two-slot
// ping-pong buffer and streams each frame out one word per beat over a
// valid/ready interface. Words leave in packed-index order (plane fastest,
// then column, then row) with their decoded coordinates and the mode bits
// captured alongside the frame.
module sa_out_drain #(
  parameter int N      = 8,
  parameter int PLANES = 3,
  parameter int ROWS   = 4,
  parameter int COLS   = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [PLANES*ROWS*COLS*2*N-1:0]  sa_out,
  input  logic                             sa_out_valid,
  input  logic                             select0,
  input  logic                             select1,
  input  logic                             flush,
  output logic [2*N-1:0]                   m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic [1:0]                       m_plane,
  output logic [1:0]                       m_row,
  output logic [2:0]                       m_col,
  output logic [1:0]                       m_mode,
  output logic [1:0]                       frames_pending,
  output logic [7:0]                       drop_cnt
);

  localparam int WORD_W  = 2 * N;
  localparam int WORDS   = PLANES * ROWS * COLS;
  localparam int FRAME_W = WORDS * WORD_W;
  localparam int BEAT_W  = $clog2(WORDS);

  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(WORDS - 1);
  localparam logic [1:0]        PLANE_MAX = 2'(PLANES - 1);
  localparam logic [2:0]        COL_MAX   = 3'(COLS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Control state
  state_t              state, state_next;
  logic [1:0]          occ, occ_next;
  logic                wp, wp_next;
  logic                rp, rp_next;
  logic [BEAT_W-1:0]   beat, beat_next;
  logic [1:0]          plane, plane_next;
  logic [1:0]          row, row_next;
  logic [2:0]          col, col_next;
  logic [7:0]          drops, drops_next;

  // Frame storage; contents are never cleared, only overwritten by captures
  logic [FRAME_W-1:0]  frame_mem [2];
  logic [1:0]          mode_mem  [2];

  // Per-cycle decisions
  logic                handshake;
  logic                beat_last;
  logic                last_handshake;
  logic                slot_free;
  logic                capture;
  logic                drop;

  logic [FRAME_W-1:0]  cur_frame;
  logic [WORD_W-1:0]   cur_word;

  assign m_valid        = (state == STREAM);
  assign beat_last      = (beat == BEAT_MAX);
  assign handshake      = m_valid && m_ready;
  assign last_handshake = handshake && beat_last;
  // A full buffer still has room when the draining frame finishes this cycle.
  assign slot_free      = (occ != 2'd2) || last_handshake;
  assign capture        = sa_out_valid && slot_free && !flush;
  assign drop           = sa_out_valid && !slot_free && !flush;

  // Next-state and counter update logic; flush overrides everything
  always_comb begin
    state_next = state;
    occ_next   = occ;
    wp_next    = wp;
    rp_next    = rp;
    beat_next  = beat;
    plane_next = plane;
    row_next   = row;
    col_next   = col;
    drops_next = drops;

    if (flush) begin
      state_next = IDLE;
      occ_next   = 2'd0;
      wp_next    = 1'b0;
      rp_next    = 1'b0;
      beat_next  = '0;
      plane_next = 2'd0;
      row_next   = 2'd0;
      col_next   = 3'd0;
      drops_next = 8'd0;
    end else begin
      if (capture) begin
        wp_next = ~wp;
      end

      if (drop && (drops != 8'hFF)) begin
        drops_next = drops + 8'd1;
      end

      if (capture && !last_handshake) begin
        occ_next = occ + 2'd1;
      end else if (!capture && last_handshake) begin
        occ_next = occ - 2'd1;
      end

      // Beat counter walks plane fastest, then column, then row.
      if (handshake) begin
        if (beat_last) begin
          beat_next  = '0;
          plane_next = 2'd0;
          col_next   = 3'd0;
          row_next   = 2'd0;
          rp_next    = ~rp;
        end else begin
          beat_next = beat + BEAT_W'(1);
          if (plane == PLANE_MAX) begin
            plane_next = 2'd0;
            if (col == COL_MAX) begin
              col_next = 3'd0;
              row_next = row + 2'd1;
            end else begin
              col_next = col + 3'd1;
            end
          end else begin
            plane_next = plane + 2'd1;
          end
        end
      end

      // Streaming continues as long as any frame remains buffered, which
      // gives back-to-back frames without a bubble.
      state_next = (occ_next != 2'd0) ? STREAM : IDLE;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      occ   <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      beat  <= '0;
      plane <= 2'd0;
      row   <= 2'd0;
      col   <= 3'd0;
      drops <= 8'd0;
    end else begin
      state <= state_next;
      occ   <= occ_next;
      wp    <= wp_next;
      rp    <= rp_next;
      beat  <= beat_next;
      plane <= plane_next;
      row   <= row_next;
      col   <= col_next;
      drops <= drops_next;
    end
  end

  // Frame and mode-tag capture into the write slot (data path, not reset)
  always_ff @(posedge clk) begin
    if (capture) begin
      frame_mem[wp] <= sa_out;
      mode_mem[wp]  <= {select1, select0};
    end
  end

  assign cur_frame = frame_mem[rp];

  // Word select from the draining slot using the registered beat index
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (beat == BEAT_W'(i)) begin
        cur_word = cur_frame[i*WORD_W +: WORD_W];
      end
    end
  end

  // Storage is not reset, so data and mode are gated to zero outside STREAM.
  assign m_data         = m_valid ? cur_word : '0;
  assign m_mode         = m_valid ? mode_mem[rp] : 2'd0;
  assign m_last         = m_valid && beat_last;
  assign m_plane        = plane;
  assign m_row          = row;
  assign m_col          = col;
  assign frames_pending = occ;
  assign drop_cnt       = drops;

endmodule

// File: doc/sa_out_drain.md
# sa_out_drain

Output-side collector for the systolic array (SA). Snapshots one full frame of SA partial-sum outputs (3 planes × 4 rows × 8 columns, 2N bits each) on a capture strobe into a two-frame ping-pong buffer. Streams each frame out one word per beat over a valid/ready interface. This is the consumer end of the SA port set that the array testbench drives.

## Interface
- N, default 8: SA operand width; each output word is 2N bits.
- PLANES, default 3: output planes (out0xx, out1xx, out2xx).
- ROWS, default 4: rows per plane.
- COLS, default 8: columns per row.
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sa_out  in  PLANES*ROWS*COLS*2N  packed SA outputs.
  - Word idx = ((r-1)*COLS+(c-1))*PLANES+p sits at sa_out[idx*2N +: 2N], for out{p}{r}{c}, p 0-based, r and c 1-based.
- sa_out_valid  in  1  capture strobe; frame is valid this cycle.
- select0, select1  in  1 each  SA mode bits; captured with the frame.
- flush  in  1  synchronous clear of buffers and stream state.
- m_data  out  2N  current output word.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the word.
- m_last  out  1  asserted on the final word of a frame.
- m_plane  out  2, m_row  out  2, m_col  out  3  zero-based coordinates of the current word.
- m_mode  out  2  {select1,select0} captured with the frame being drained.
- frames_pending  out  2  number of occupied buffers (0..2).
- drop_cnt  out  8  saturating count of rejected captures.

## Operation
- Buffer: two frame slots plus per-slot mode tags. Write pointer wp, read pointer rp, occupancy count.
- Capture: on a clk edge with sa_out_valid=1 and a slot free, write the whole sa_out vector and {select1,select0} into slot wp, toggle wp, and increment occupancy.
- A slot counts as free if occupancy<2, or if the last beat of the draining frame handshakes in the same cycle.
  - Same-cycle capture into the freed slot is accepted; occupancy stays 2.
- Drop: sa_out_valid=1 with no free slot. Buffer is unchanged and drop_cnt increments, saturating at 255.
- State machine:
  - IDLE: entered when occupancy is 0. m_valid=0.
  - STREAM: entered when occupancy>0. m_valid=1.
- STREAM drain:
  - m_data is taken from slot rp at beat index b (0..PLANES*ROWS*COLS-1), in packed-index order with plane fastest, then column, then row.
  - m_plane/m_col/m_row are the decoded b.
- Beat advance: m_valid && m_ready advances b.
  - At b = last (95 with defaults), b wraps to 0, rp toggles, and occupancy decrements (unless a capture is accepted the same cycle).
  - The next buffered frame then starts on the following beat with no bubble. Otherwise the block returns to IDLE.
- m_last = m_valid && (b == PLANES*ROWS*COLS-1).
- flush has priority over capture and handshake:
  - occupancy, wp, rp, b and drop_cnt go to 0; the block goes to IDLE.
  - Buffer contents are not cleared.
- No arithmetic on data; words pass through bit-exact.

## Timing
- Reset values (asynchronous on reset_n=0): m_valid=0, m_last=0, m_data=0, m_plane=m_row=m_col=0, m_mode=0, frames_pending=0, drop_cnt=0, state IDLE, wp=rp=b=0.
- Capture-to-first-beat latency: 1 cycle. Capture at edge k gives m_valid=1 with word 0 after edge k.
- While m_valid=1 and m_ready=0, m_data, coordinates, m_last and m_mode hold stable.
- Throughput: 1 word/cycle with m_ready held high. One frame is 96 cycles; back-to-back frames have no gap.
- Outputs are registered or decoded only from registered state; no combinational path from m_ready or sa_out to the outputs.
- Reset mid-stream abandons the frame; after release, the block stays IDLE until the next capture.

## Test plan
- Reset, then capture a frame with word idx = idx+1 (select0=1, select1=0), m_ready=1.
  - Expect m_valid one cycle later, words 1..96 in order, and m_mode=01.
  - Beat 0: coordinates (p,r,c)=(0,0,0). Beat 3: (0,0,1). Beat 95: (2,3,7) with m_last=1.
- Same frame with m_ready toggling 1,0,1,0.
  - Each word is held while m_ready=0.
  - 96 accepted words, no duplicates, no skips.
- Three captures on consecutive cycles with m_ready=0.
  - frames_pending=2 and drop_cnt=1.
  - Releasing m_ready drains frames 1 and 2 back-to-back with no gap.
- Both slots full and sa_out_valid asserted on the cycle frame 1's last beat handshakes.
  - Capture is accepted, drop_cnt stays unchanged, and frames_pending stays 2.
- Assert flush mid-frame at beat 40.
  - Next cycle: m_valid=0 and frames_pending=0.
  - A new capture restarts at beat 0.
- 300 captures with m_ready=0.
  - drop_cnt saturates at 255.
- Assert reset_n=0 mid-stream.
  - All outputs return immediately to their reset values.
